// File: rtl/hash_display_ctrl_if.sv
// Miner-to-display handshake: one input block / digest pair per valid&ready.
interface hash_display_ctrl_if;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] in_hash;
    logic [255:0]  out_hash;

    modport master (
        output in_valid,
        output in_hash,
        output out_hash,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_hash,
        input  out_hash,
        output in_ready
    );
endinterface

// File: rtl/hash_display_ctrl.sv
// Tear-free hash display sequencer: accepts a hash pair into shadow registers,
// commits it to the renderer only at the start of vertical blanking, then holds
// it on screen for MIN_FRAMES vblank starts before taking the next pair.
module hash_display_ctrl #(
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned MIN_FRAMES = 30,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [10:0]         y,
    input  logic                freeze,
    hash_display_ctrl_if.slave  in_bus,
    output logic [1023:0]       disp_inhash,
    output logic [255:0]        disp_outhash,
    output logic                commit,
    output logic                pending,
    output logic [CNT_W-1:0]    frame_count
);

    localparam int unsigned DW = (MIN_FRAMES == 0) ? 1 : $clog2(MIN_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = (MIN_FRAMES == 0) ? '0 : DW'(MIN_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        DWELL
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            vb;
    logic            vb_d;
    logic            vrise;
    logic            ready_c;
    logic            accept;
    logic            do_commit;
    logic [DW-1:0]   dwell;
    logic [1023:0]   shadow_in;
    logic [255:0]    shadow_out;

    assign vb        = (y >= 11'(V_ACTIVE));
    assign vrise     = vb & ~vb_d;
    assign accept    = in_bus.in_valid & ready_c;
    assign do_commit = (state == PEND) & vrise & ~freeze;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, commit on an unfrozen vblank start, then dwell.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = PEND;
            PEND:    if (do_commit) state_nxt = DWELL;
            DWELL: begin
                if (MIN_FRAMES == 0) begin
                    state_nxt = IDLE;
                end else if (vrise && (dwell == DWELL_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: ready is purely a function of state and reset.
    always_comb begin
        ready_c = (state == IDLE) && !reset;
        in_bus.in_ready = ready_c;
    end

    // Datapath: vblank edge tracking, frame counter, shadow/display registers, dwell count.
    always_ff @(posedge clk) begin
        if (reset) begin
            vb_d         <= 1'b1;
            frame_count  <= '0;
            shadow_in    <= '0;
            shadow_out   <= '0;
            disp_inhash  <= '0;
            disp_outhash <= '0;
            pending      <= 1'b0;
            commit       <= 1'b0;
            dwell        <= '0;
        end else begin
            vb_d   <= vb;
            commit <= 1'b0;
            if (vrise) begin
                frame_count <= frame_count + CNT_W'(1);
            end
            if (accept) begin
                shadow_in  <= in_bus.in_hash;
                shadow_out <= in_bus.out_hash;
                pending    <= 1'b1;
            end
            if (do_commit) begin
                disp_inhash  <= shadow_in;
                disp_outhash <= shadow_out;
                pending      <= 1'b0;
                commit       <= 1'b1;
                dwell        <= '0;
            end else if ((state == DWELL) && vrise) begin
                dwell <= dwell + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hash_display_ctrl.sv
// Randomized bench for hash_display_ctrl: two instances (MIN_FRAMES=2 with a
// 4-bit frame counter, MIN_FRAMES=0 with the default counter) share stimulus
// and are compared every cycle against a frame-level reference model.
module tb_hash_display_ctrl;

    localparam int VA = 6;
    localparam int VT = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   y;
    logic          frz;
    logic          vld;
    logic [1023:0] ih;
    logic [255:0]  oh;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hash_display_ctrl_if bus0 ();
    hash_display_ctrl_if bus1 ();

    assign bus0.in_valid = vld;
    assign bus0.in_hash  = ih;
    assign bus0.out_hash = oh;
    assign bus1.in_valid = vld;
    assign bus1.in_hash  = ih;
    assign bus1.out_hash = oh;

    logic [1023:0] d0_in,  d1_in;
    logic [255:0]  d0_out, d1_out;
    logic          c0, c1, p0, p1;
    logic [3:0]    f0;
    logic [15:0]   f1;

    hash_display_ctrl #(.V_ACTIVE(VA), .MIN_FRAMES(2), .CNT_W(4)) dut0 (
        .clk(clk), .reset(rst), .y(y), .freeze(frz), .in_bus(bus0.slave),
        .disp_inhash(d0_in), .disp_outhash(d0_out), .commit(c0),
        .pending(p0), .frame_count(f0)
    );

    hash_display_ctrl #(.V_ACTIVE(VA), .MIN_FRAMES(0), .CNT_W(16)) dut1 (
        .clk(clk), .reset(rst), .y(y), .freeze(frz), .in_bus(bus1.slave),
        .disp_inhash(d1_in), .disp_outhash(d1_out), .commit(c1),
        .pending(p1), .frame_count(f1)
    );

    // Reference model: pair in shadow, frames still to wait before accepting,
    // commit pulse, last-seen blanking level and frame counter.
    int            mf[2] = '{2, 0};
    int            cw[2] = '{4, 16};
    logic          m_pend[2];
    int            m_lock[2];
    logic          m_commit[2];
    logic          m_vbp[2];
    int            m_frame[2];
    logic [1023:0] m_sin[2], m_din[2];
    logic [255:0]  m_sout[2], m_dout[2];

    function automatic logic [1023:0] rnd_block();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic vbm, vr, rdy, nc;
            vbm = (int'(y) >= VA);
            vr  = vbm && !m_vbp[k];
            if (rst) begin
                m_pend[k] = 0; m_lock[k] = 0; m_commit[k] = 0; m_vbp[k] = 1;
                m_frame[k] = 0; m_sin[k] = '0; m_din[k] = '0; m_sout[k] = '0; m_dout[k] = '0;
            end else begin
                rdy = !m_pend[k] && (m_lock[k] == 0) && !m_commit[k];
                nc  = 0;
                if (vr) m_frame[k] = (m_frame[k] + 1) % (1 << cw[k]);
                if (m_pend[k] && vr && !frz) begin
                    m_din[k] = m_sin[k]; m_dout[k] = m_sout[k];
                    m_pend[k] = 0; m_lock[k] = mf[k]; nc = 1;
                end else if (m_lock[k] > 0 && vr) begin
                    m_lock[k]--;
                end
                if (rdy && vld) begin
                    m_sin[k] = ih; m_sout[k] = oh; m_pend[k] = 1;
                end
                m_commit[k] = nc;
                m_vbp[k]    = vbm;
            end
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int w;
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            w = 0;
            for (int i = 15; i >= 0; i--) if (got[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
            $error("FAIL %s: word %0d observed %h expected %h", tag, w, got[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    task automatic check_all();
        logic er0, er1;
        er0 = !rst && !m_pend[0] && (m_lock[0] == 0) && !m_commit[0];
        er1 = !rst && !m_pend[1] && (m_lock[1] == 0) && !m_commit[1];
        chk_bit("ready0",   bus0.in_ready, er0);
        chk_bit("pending0", p0, m_pend[0]);
        chk_bit("commit0",  c0, m_commit[0]);
        chk_vec("inhash0",  d0_in, m_din[0]);
        chk_vec("outhash0", 1024'(d0_out), 1024'(m_dout[0]));
        chk_vec("frames0",  1024'(f0), 1024'(m_frame[0]));
        chk_bit("ready1",   bus1.in_ready, er1);
        chk_bit("pending1", p1, m_pend[1]);
        chk_bit("commit1",  c1, m_commit[1]);
        chk_vec("inhash1",  d1_in, m_din[1]);
        chk_vec("outhash1", 1024'(d1_out), 1024'(m_dout[1]));
        chk_vec("frames1",  1024'(f1), 1024'(m_frame[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic adv_y();
        y = 11'((int'(y) + 1) % VT);
    endtask

    initial begin
        int guard;
        rst = 1; y = 11'(VT - 2); frz = 0; vld = 0; ih = '0; oh = '0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_lock[k] = 0; m_commit[k] = 0; m_vbp[k] = 1; m_frame[k] = 0;
            m_sin[k] = '0; m_din[k] = '0; m_sout[k] = '0; m_dout[k] = '0;
        end
        @(negedge clk);

        // Reset held inside blanking, released inside blanking.
        for (int i = 0; i < 5; i++) tick();
        rst = 0;
        tick();
        tick();
        for (int i = 0; i < 12; i++) begin adv_y(); tick(); end

        // Directed single pair, then let it commit and dwell out.
        vld = 1;
        for (int i = 0; i < 128; i++) ih[i*8 +: 8] = 8'hA5;
        oh = 256'h1234;
        adv_y(); tick();
        vld = 0; ih = '0; oh = '0;
        for (int i = 0; i < 4 * VT; i++) begin adv_y(); tick(); end

        // Sparse random traffic with per-frame random freeze.
        for (int i = 0; i < 1500; i++) begin
            adv_y();
            if (y == 0) frz = ($urandom_range(0, 2) == 0);
            vld = ($urandom_range(0, 3) == 0);
            ih = rnd_block(); oh = 256'(rnd_block());
            tick();
        end

        // Continuous input, no freeze: back-to-back throughput.
        frz = 0;
        for (int i = 0; i < 400; i++) begin
            adv_y(); vld = 1; ih = rnd_block(); oh = 256'(rnd_block());
            tick();
        end

        // Reset while a pair is pending in the MIN_FRAMES=2 instance.
        guard = 0;
        while (!m_pend[0] && guard < 200) begin
            adv_y(); vld = 1; ih = rnd_block(); oh = 256'(rnd_block());
            tick(); guard++;
        end
        n_cmp++;
        assert (guard < 200) else begin
            n_fail++;
            $error("FAIL pend_wait: observed timeout after %0d cycles expected pending", guard);
        end
        rst = 1; vld = 0;
        adv_y(); tick();
        adv_y(); tick();
        rst = 0;

        // Random traffic with occasional resets and freezes.
        for (int i = 0; i < 800; i++) begin
            adv_y();
            if (y == 0) frz = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 150) == 0);
            vld = ($urandom_range(0, 1) == 0);
            ih = rnd_block(); oh = 256'(rnd_block());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
